mult_share_sched: RTL

- Shares one pipelined unsigned multiplier between NUM_REQ requesters. Each requester has its own valid/ready request port; results return on a single shared valid/ready response bus, tagged with the requester ID.
- Sits behind the multiplier's AXI4-Lite register front end, or beside other masters that need products. It arbitrates requesters round-robin, tracks in-flight operations and applies back-pressure.

---
 rtl/mult_share_sched.sv | 112 +++++++++++
 1 files changed

// File: rtl/mult_share_sched.sv
`timescale 1ns/1ps
// Shares one pipelined unsigned multiplier among NUM_REQ requesters using
// round-robin arbitration; results come back in acceptance order, tagged by ID.
module mult_share_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 3,
    parameter int ID_WIDTH    = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic                            busy,
    output logic [15:0]                     done_cnt
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PIPE_STAGES-1:0] r_vld;
    logic [ID_WIDTH-1:0]    r_id   [PIPE_STAGES];
    logic [PW-1:0]          r_prod [PIPE_STAGES];
    logic [ID_WIDTH-1:0]    r_last_gnt;
    logic [15:0]            r_done;

    logic                   w_en;
    logic                   w_found;
    logic                   w_hs;
    logic [ID_WIDTH-1:0]    w_win;
    logic [DATA_WIDTH-1:0]  w_a;
    logic [DATA_WIDTH-1:0]  w_b;
    logic [PW-1:0]          w_prod;

    assign w_en = !r_vld[PIPE_STAGES-1] || rsp_ready;

    // Search starts one past the last winner so every waiting requester is
    // reached within NUM_REQ grants.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_gnt) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = ID_WIDTH'(idx);
            end
        end
    end

    assign w_hs = ARESETN && w_found && w_en;

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign w_a    = req_a[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    assign w_b    = req_b[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod = PW'(w_a) * PW'(w_b);

    // Data/ID registers only load alongside a valid operation, so bubbles and
    // idle cycles leave the response payload untouched.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_vld      <= '0;
            r_last_gnt <= ID_WIDTH'(NUM_REQ - 1);
            r_done     <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_id[i]   <= '0;
                r_prod[i] <= '0;
            end
        end else begin
            if (w_en) begin
                r_vld[0] <= w_hs;
                if (w_hs) begin
                    r_id[0]   <= w_win;
                    r_prod[0] <= w_prod;
                end
                for (int i = 1; i < PIPE_STAGES; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_id[i]   <= r_id[i-1];
                        r_prod[i] <= r_prod[i-1];
                    end
                end
            end
            if (w_hs) begin
                r_last_gnt <= w_win;
            end
            if (r_vld[PIPE_STAGES-1] && rsp_ready) begin
                r_done <= r_done + 16'd1;
            end
        end
    end

    assign rsp_valid = r_vld[PIPE_STAGES-1];
    assign rsp_data  = r_prod[PIPE_STAGES-1];
    assign rsp_id    = r_id[PIPE_STAGES-1];
    assign busy      = |r_vld;
    assign done_cnt  = r_done;

endmodule
